// File: rtl/bch_encode_par_pkg.sv
// Shared BCH helpers: FSM state type, GF(2^M) arithmetic and the binary
// generator polynomial g(x) for a narrow-sense BCH code of length N = 2^M-1
// correcting T errors. Everything here is evaluated at elaboration time.
package bch_encode_par_pkg;

  localparam int unsigned MaxM    = 8;    // largest supported field, GF(2^8)
  localparam int unsigned MaxPoly = 256;  // bit capacity for g(x) coefficients

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } state_e;

  // Field degree for codeword length n = 2^M - 1.
  function automatic int unsigned bch_m(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Primitive polynomial (including x^m term) used to build GF(2^m).
  function automatic logic [MaxM:0] gf_prim_poly(input int unsigned m);
    logic [MaxM:0] p;
    case (m)
      2:       p = 9'b000000111;
      3:       p = 9'b000001011;
      4:       p = 9'b000010011;
      5:       p = 9'b000100101;
      6:       p = 9'b001000011;
      7:       p = 9'b010001001;
      default: p = 9'b100011101;
    endcase
    return p;
  endfunction

  // Multiply two GF(2^m) elements in polynomial basis.
  function automatic logic [MaxM-1:0] gf_mul(input logic [MaxM-1:0] a, input logic [MaxM-1:0] b,
                                             input int unsigned m);
    logic [MaxM:0] aa;
    logic [MaxM:0] p;
    logic [MaxM:0] prim;
    aa   = {1'b0, a};
    p    = '0;
    prim = gf_prim_poly(m);
    for (int unsigned i = 0; i < MaxM; i++) begin
      if (i < m) begin
        if (b[i]) p = p ^ aa;
        aa = aa << 1;
        if (aa[m]) aa = aa ^ prim;
      end
    end
    return p[MaxM-1:0];
  endfunction

  // g(x) = product of (x + alpha^j) over every j in the cyclotomic cosets of
  // alpha^1 .. alpha^2T. The product of a full coset set has binary coefficients,
  // so bit 0 of each GF coefficient is the polynomial bit.
  function automatic logic [MaxPoly-1:0] bch_encoder_poly(input int unsigned n,
                                                          input int unsigned t);
    int unsigned          m;
    int unsigned          j;
    int unsigned          deg;
    logic [MaxPoly-1:0]   root;
    logic [MaxM-1:0]      coef [MaxPoly];
    logic [MaxM-1:0]      a;
    logic [MaxPoly-1:0]   g;
    m    = bch_m(n);
    root = '0;
    for (int unsigned i = 1; i <= 2 * t; i++) begin
      j = i % n;
      for (int unsigned k = 0; k < m; k++) begin
        root[j] = 1'b1;
        j = (2 * j) % n;
      end
    end
    for (int i = 0; i < MaxPoly; i++) coef[i] = '0;
    coef[0] = MaxM'(1);
    deg     = 0;
    a       = MaxM'(1);
    for (int unsigned e = 0; e < n; e++) begin
      if (root[e]) begin
        for (int k = int'(deg) + 1; k > 0; k--) begin
          coef[k] = coef[k-1] ^ gf_mul(coef[k], a, m);
        end
        coef[0] = gf_mul(coef[0], a, m);
        deg     = deg + 1;
      end
      a = gf_mul(a, MaxM'(2), m);
    end
    g = '0;
    for (int i = 0; i < MaxPoly; i++) g[i] = coef[i][0];
    return g;
  endfunction

endpackage

// File: rtl/bch_encode_lfsr.sv
// Combinational W-step remainder update for the systematic BCH encoder.
// Ports:
//   rem_i  - current N-K bit remainder
//   data_i - message word, bit W-1 is consumed first
//   rem_o  - remainder after W serial LFSR steps
module bch_encode_lfsr
  import bch_encode_par_pkg::*;
#(
  parameter int unsigned N = 15,
  parameter int unsigned K = 5,
  parameter int unsigned T = 3,
  parameter int unsigned W = 1
) (
  input  logic [N-K-1:0] rem_i,
  input  logic [W-1:0]   data_i,
  output logic [N-K-1:0] rem_o
);

  localparam int unsigned        R       = N - K;
  localparam logic [MaxPoly-1:0] GenPoly = bch_encoder_poly(N, T);
  // x^R term is implicit in the shift; only the lower taps feed back.
  localparam logic [R-1:0]       GenTaps = GenPoly[R-1:0];

  if (GenPoly[R] != 1'b1) begin : g_deg_check
    $error("generator degree does not match N-K");
  end

  logic [R-1:0] rem;
  logic         fb;

  always_comb begin
    rem = rem_i;
    fb  = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      fb  = rem[R-1] ^ data_i[i];
      rem = {rem[R-2:0], 1'b0} ^ ({R{fb}} & GenTaps);
    end
    rem_o = rem;
  end

endmodule

// File: rtl/bch_encode_par.sv
// Word-serial systematic BCH encoder with valid/ready handshakes.
// Message words pass straight through a one-entry output register while the
// remainder accumulates; the parity words are then shifted out of it.
// Ports:
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   in_valid_i/in_ready_o     - message word handshake, in_data_i (bit W-1 first)
//   out_valid_o/out_ready_i   - codeword word handshake, out_data_o
//   out_first_o / out_last_o  - first message word / final parity word markers
module bch_encode_par
  import bch_encode_par_pkg::*;
#(
  parameter int unsigned N = 15,
  parameter int unsigned K = 5,
  parameter int unsigned T = 3,
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_first_o,
  output logic         out_last_o
);

  localparam int unsigned R       = N - K;
  localparam int unsigned M       = bch_m(N);
  localparam int unsigned NumMsg  = K / W;
  localparam int unsigned NumPar  = R / W;
  localparam int unsigned MsgCntW = $clog2(NumMsg + 1);
  localparam int unsigned ParCntW = $clog2(NumPar + 1);

  if ((K % W) != 0 || (R % W) != 0 || K < W) begin : g_width_check
    $error("K and N-K must be multiples of W");
  end
  if (N != (1 << M) - 1) begin : g_len_check
    $error("N must be 2^M-1");
  end

  state_e               state_q, state_d;
  logic [R-1:0]         rem_q, rem_d, rem_next;
  logic [MsgCntW-1:0]   msg_cnt_q, msg_cnt_d;
  logic [ParCntW-1:0]   par_cnt_q, par_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 out_first_q, out_first_d;
  logic                 out_last_q, out_last_d;
  logic                 out_free;
  logic                 in_acc;

  bch_encode_lfsr #(
    .N(N),
    .K(K),
    .T(T),
    .W(W)
  ) u_lfsr (
    .rem_i (rem_q),
    .data_i(in_data_i),
    .rem_o (rem_next)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    msg_cnt_d   = msg_cnt_q;
    par_cnt_d   = par_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    // Output register can take a new word if empty or draining this cycle.
    out_free   = !out_valid_q || out_ready_i;
    in_ready_o = rst_ni && (state_q != StParity) && out_free;
    in_acc     = in_valid_i && in_ready_o;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    unique case (state_q)
      StIdle, StData: begin
        if (in_acc) begin
          rem_d       = rem_next;
          out_valid_d = 1'b1;
          out_data_d  = in_data_i;
          out_first_d = (msg_cnt_q == '0);
          out_last_d  = 1'b0;
          if (msg_cnt_q == MsgCntW'(NumMsg - 1)) begin
            msg_cnt_d = '0;
            state_d   = StParity;
          end else begin
            msg_cnt_d = msg_cnt_q + MsgCntW'(1);
            state_d   = StData;
          end
        end
      end
      StParity: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = rem_q[R-1 -: W];
          out_first_d = 1'b0;
          out_last_d  = (par_cnt_q == ParCntW'(NumPar - 1));
          rem_d       = rem_q << W;
          if (par_cnt_q == ParCntW'(NumPar - 1)) begin
            // Final parity word is now in the output register, so the next
            // message can be accepted as that word drains.
            par_cnt_d = '0;
            rem_d     = '0;
            state_d   = StIdle;
          end else begin
            par_cnt_d = par_cnt_q + ParCntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      msg_cnt_q   <= '0;
      par_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      msg_cnt_q   <= msg_cnt_d;
      par_cnt_q   <= par_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_bch_encode_par.sv
// Bench for the BCH(15,5,3) encoder at word widths 5 and 1.
module tb_bch_encode_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid5, in_ready5, out_valid5, out_ready5, out_first5, out_last5;
  logic [4:0] in_data5, out_data5;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_first1, out_last1;
  logic [0:0] in_data1, out_data1;

  bch_encode_par #(.N(15), .K(5), .T(3), .W(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid5), .in_ready_o(in_ready5), .in_data_i(in_data5),
    .out_valid_o(out_valid5), .out_ready_i(out_ready5), .out_data_o(out_data5),
    .out_first_o(out_first5), .out_last_o(out_last5)
  );

  bch_encode_par #(.N(15), .K(5), .T(3), .W(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_data_i(in_data1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_data_o(out_data1),
    .out_first_o(out_first1), .out_last_o(out_last1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted output words: {first, last, data}.
  logic [6:0] q5[$];
  logic [2:0] q1[$];
  int         rule_err = 0;
  int         hold_err = 0;
  logic       stall_prev = 1'b0;
  logic [6:0] held;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid5 && out_ready5) q5.push_back({out_first5, out_last5, out_data5});
      if (out_valid1 && out_ready1) q1.push_back({out_first1, out_last1, out_data1});
      // With one message word per codeword the encoder may only take input when
      // nothing is pending, or when the final parity word leaves this cycle.
      if (in_ready5 !== (!out_valid5 || (out_last5 && out_ready5))) rule_err <= rule_err + 1;
      if (stall_prev && (!out_valid5 || {out_first5, out_last5, out_data5} !== held))
        hold_err <= hold_err + 1;
      stall_prev <= out_valid5 && !out_ready5;
      held       <= {out_first5, out_last5, out_data5};
    end else begin
      stall_prev <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Codeword by polynomial long division with g = x^10+x^8+x^5+x^4+x^2+x+1.
  function automatic logic [14:0] cw_ref(input logic [4:0] m);
    logic [14:0] r;
    r = {m, 10'b0};
    for (int i = 14; i >= 10; i--) if (r[i]) r = r ^ (15'h537 << (i - 10));
    return {m, r[9:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send5(input logic [4:0] m);
    logic r;
    logic ok;
    ok        = 1'b0;
    in_valid5 = 1'b1;
    in_data5  = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = in_ready5;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid5 = 1'b0;
    check("send5_accept", 32'(ok), 32'd1);
  endtask

  task automatic send1(input logic b);
    logic r;
    logic ok;
    ok        = 1'b0;
    in_valid1 = 1'b1;
    in_data1  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = in_ready1;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid1 = 1'b0;
    check("send1_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_q5(input int n, input string name);
    for (int i = 0; i < 25000 && q5.size() < n; i++) step();
    check(name, q5.size(), n);
  endtask

  // Pop one W=5 codeword; returns {f0,l0,f1,l1,f2,l2, 15-bit codeword}.
  task automatic pop_cw(output logic [20:0] got);
    logic [6:0] e [3];
    for (int w = 0; w < 3; w++) e[w] = (q5.size() > 0) ? q5.pop_front() : 7'h7f;
    got = {e[0][6:5], e[1][6:5], e[2][6:5], e[0][4:0], e[1][4:0], e[2][4:0]};
  endtask

  typedef struct {
    logic [4:0]  msg;
    logic [14:0] cw;
  } vec_t;

  vec_t        vecs [5];
  logic [4:0]  msgs [$];
  logic [4:0]  b2b  [4];
  logic [20:0] got;
  logic [14:0] stream, fmask, lmask;
  logic [2:0]  e1;
  int          low;
  int          acc_cyc [4];
  logic        r;
  logic        ok;

  initial begin
    vecs[0] = '{5'b00001, 15'b00001_01001_10111};
    vecs[1] = '{5'b00000, 15'b00000_00000_00000};
    vecs[2] = '{5'b00010, 15'b00010_10011_01110};
    vecs[3] = '{5'b00011, 15'b00011_11010_11001};
    vecs[4] = '{5'b00100, 15'b00100_01111_01011};
    b2b     = '{5'h01, 5'h1f, 5'h0a, 5'h15};

    rst_n = 1'b0;
    in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid5", 32'(out_valid5), 32'd0);
    check("rst_out_first5", 32'(out_first5), 32'd0);
    check("rst_out_last5", 32'(out_last5), 32'd0);
    check("rst_out_data5", 32'(out_data5), 32'd0);
    check("rst_in_ready5", 32'(in_ready5), 32'd0);
    check("rst_in_ready1", 32'(in_ready1), 32'd0);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready5", 32'(in_ready5), 32'd1);

    // Table-driven single codewords, W=5
    for (int i = 0; i < 5; i++) begin
      q5.delete();
      send5(vecs[i].msg);
      wait_q5(3, $sformatf("vec%0d_count", i));
      pop_cw(got);
      check($sformatf("vec%0d_cw", i), 32'(got), {11'd0, 6'b100001, vecs[i].cw});
    end

    // W=1 bit stream for message 00001
    q1.delete();
    for (int i = 4; i >= 0; i--) send1(i == 0);
    for (int i = 0; i < 200 && q1.size() < 15; i++) step();
    check("w1_count", q1.size(), 15);
    stream = '0; fmask = '0; lmask = '0;
    for (int i = 0; i < 15; i++) begin
      e1 = (q1.size() > 0) ? q1.pop_front() : 3'b111;
      fmask[14-i]  = e1[2];
      lmask[14-i]  = e1[1];
      stream[14-i] = e1[0];
    end
    check("w1_stream", 32'(stream), 32'(15'b000010100110111));
    check("w1_first", 32'(fmask), 32'(15'b100000000000000));
    check("w1_last", 32'(lmask), 32'(15'b000000000000001));

    // Reset while parity is pending, then a fresh codeword
    q5.delete();
    out_ready5 = 1'b0;
    send5(5'b10110);
    step();
    check("mid_parity_valid", 32'(out_valid5), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid5), 32'd0);
    check("async_rst_in_ready", 32'(in_ready5), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    out_ready5 = 1'b1;
    step();
    q5.delete();
    send5(5'b00001);
    wait_q5(3, "after_rst_count");
    pop_cw(got);
    check("after_rst_cw", 32'(got), {11'd0, 6'b100001, 15'b00001_01001_10111});

    // Random messages with 50% output stalls
    q5.delete();
    msgs.delete();
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [4:0] m;
          m = 5'($urandom_range(0, 31));
          msgs.push_back(m);
          send5(m);
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        for (int c = 0; c < 20000 && q5.size() < 300; c++) begin
          out_ready5 = 1'($urandom_range(0, 1));
          step();
        end
        out_ready5 = 1'b1;
      end
    join
    wait_q5(300, "rand_count");
    for (int i = 0; i < 100; i++) begin
      pop_cw(got);
      check($sformatf("rand%0d_cw", i), 32'(got), {11'd0, 6'b100001, cw_ref(msgs[i])});
    end
    step();
    check("rand_extra_words", q5.size(), 0);

    // Back-to-back codewords with out_ready held high
    q5.delete();
    out_ready5 = 1'b1;
    in_valid5  = 1'b1;
    low        = 0;
    for (int i = 0; i < 4; i++) begin
      in_data5 = b2b[i];
      ok = 1'b0;
      for (int j = 0; j < 50; j++) begin
        @(negedge clk);
        r = in_ready5;
        if (!r) low++;
        step();
        if (r) begin
          acc_cyc[i] = cyc;
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("b2b%0d_accept", i), 32'(ok), 32'd1);
    end
    in_valid5 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (!in_ready5) low++;
      step();
    end
    check("b2b_ready_low_cycles", low, 8);
    check("b2b_accept_span", acc_cyc[3] - acc_cyc[0], 9);
    wait_q5(12, "b2b_count");
    for (int i = 0; i < 4; i++) begin
      pop_cw(got);
      check($sformatf("b2b%0d_cw", i), 32'(got), {11'd0, 6'b100001, cw_ref(b2b[i])});
    end

    step();
    check("in_ready_rule", rule_err, 0);
    check("stall_hold", hold_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
